// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default thresholds for the synchronous FIFO controller.
package fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH    = 4;
    localparam int DEFAULT_AEMPTY_THRESH = 2;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int default_afull(input int addr_width);
        return depth_of(addr_width) - 2;
    endfunction

endpackage

// File: rtl/fifo_sync_ctrl_if.sv
// Request, RAM-control and status bundle between a FIFO user and the FIFO controller.
interface fifo_sync_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                              wr_req;
    logic                              rd_req;
    logic                              ram_w_en;
    logic [ADDR_WIDTH-1:0]             ram_w_addr;
    logic                              ram_r_en;
    logic [ADDR_WIDTH-1:0]             ram_r_addr;
    logic                              rd_valid;
    logic                              full;
    logic                              empty;
    logic                              almost_full;
    logic                              almost_empty;
    logic [ptr_width(ADDR_WIDTH)-1:0]  count;
    logic                              overflow;
    logic                              underflow;

    modport master (
        output wr_req, rd_req,
        input  ram_w_en, ram_w_addr, ram_r_en, ram_r_addr, rd_valid,
        input  full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_req, rd_req,
        output ram_w_en, ram_w_addr, ram_r_en, ram_r_addr, rd_valid,
        output full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer with an extra MSB wrap bit; exposes only the RAM address slice.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] addr
);
    localparam int PW = ptr_width(ADDR_WIDTH);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;

    // Natural binary overflow wraps 2**PW-1 back to 0.
    always_comb begin
        ptr_next = ptr_reg;
        if (inc) begin
            ptr_next = ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign addr = ptr_reg[ADDR_WIDTH-1:0];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller sequencing a pseudo dual-port RAM with 1-cycle read latency.
module fifo_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter int AFULL_THRESH  = default_afull(ADDR_WIDTH),
    parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_sync_ctrl_if.slave  bus
);
    localparam int            PW       = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] DEPTH_C  = PW'(depth_of(ADDR_WIDTH));
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THRESH);

    logic [PW-1:0]         count_reg;
    logic [PW-1:0]         count_next;
    logic                  rd_valid_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [1:0]            inc_vec;
    logic [ADDR_WIDTH-1:0] addr_vec [2];

    assign full  = (count_reg == DEPTH_C);
    assign empty = (count_reg == '0);

    // Write acceptance is also held off while reset is asserted so the RAM never sees a stray write.
    assign wr_acc  = bus.wr_req & ~full & rst_n;
    assign rd_acc  = bus.rd_req & ~empty;
    assign inc_vec = {rd_acc, wr_acc};

    // Index 0 is the write pointer, index 1 the read pointer.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
            fifo_ptr #(
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_ptr (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (inc_vec[gi]),
                .addr  (addr_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= '0;
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            rd_valid_reg  <= rd_acc;
            overflow_reg  <= bus.wr_req & full;
            underflow_reg <= bus.rd_req & empty;
        end
    end

    assign bus.ram_w_en     = wr_acc;
    assign bus.ram_w_addr   = addr_vec[0];
    assign bus.ram_r_en     = rd_acc;
    assign bus.ram_r_addr   = addr_vec[1];
    assign bus.rd_valid     = rd_valid_reg;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_reg >= AFULL_C);
    assign bus.almost_empty = (count_reg <= AEMPTY_C);
    assign bus.count        = count_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Bench for fifo_sync_ctrl at depth 4: directed scenarios plus random traffic against a queue model.
module tb_fifo_sync_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] wdata;
    logic [7:0] ram [DEPTH];
    logic [7:0] ram_q;
    int         n_pass  = 0;
    int         n_total = 0;
    bit         verbose = 1'b1;

    fifo_sync_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_sync_ctrl #(
        .ADDR_WIDTH    (AW),
        .AFULL_THRESH  (DEPTH - 2),
        .AEMPTY_THRESH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM owned by the parent: registered read, write data straight from the user.
    always @(posedge clk) begin
        if (bus.ram_w_en) ram[bus.ram_w_addr] <= wdata;
        if (bus.ram_r_en) ram_q <= ram[bus.ram_r_addr];
    end

    function automatic void chk(string nm, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    endfunction

    // Reference model: an ordered queue of stored words plus push/pop totals.
    logic [7:0] mq [$];
    int         m_size;
    int         m_push;
    int         m_pop;
    logic       m_rdv, m_ovf, m_unf;
    logic [7:0] m_exp;
    logic       m_wa, m_ra;

    assign m_wa = bus.wr_req && (m_size < DEPTH);
    assign m_ra = bus.rd_req && (m_size > 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_size <= 0;
            m_push <= 0;
            m_pop  <= 0;
            m_rdv  <= 1'b0;
            m_ovf  <= 1'b0;
            m_unf  <= 1'b0;
        end else begin
            if (m_ra) m_exp <= mq.pop_front();
            if (m_wa) mq.push_back(wdata);
            m_size <= m_size + int'(m_wa) - int'(m_ra);
            m_push <= m_push + int'(m_wa);
            m_pop  <= m_pop + int'(m_ra);
            m_rdv  <= m_ra;
            m_ovf  <= bus.wr_req && (m_size == DEPTH);
            m_unf  <= bus.rd_req && (m_size == 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_w_en",   bus.ram_w_en,     m_wa);
            chk("cmp_r_en",   bus.ram_r_en,     m_ra);
            chk("cmp_w_addr", bus.ram_w_addr,   m_push % DEPTH);
            chk("cmp_r_addr", bus.ram_r_addr,   m_pop % DEPTH);
            chk("cmp_count",  bus.count,        m_size);
            chk("cmp_full",   bus.full,         m_size == DEPTH);
            chk("cmp_empty",  bus.empty,        m_size == 0);
            chk("cmp_afull",  bus.almost_full,  m_size >= DEPTH - 2);
            chk("cmp_aempty", bus.almost_empty, m_size <= 2);
            chk("cmp_rdv",    bus.rd_valid,     m_rdv);
            chk("cmp_ovf",    bus.overflow,     m_ovf);
            chk("cmp_unf",    bus.underflow,    m_unf);
            chk("cmp_no_w_full",  bus.ram_w_en && bus.full,  0);
            chk("cmp_no_r_empty", bus.ram_r_en && bus.empty, 0);
            if (m_rdv) chk("cmp_rdata", ram_q, m_exp);
        end
    end

    // Drive inputs just after a rising edge and stop at the following falling edge.
    task automatic step(input bit w, input bit r, input logic [7:0] d);
        bus.wr_req = w;
        bus.rd_req = r;
        wdata      = d;
        @(negedge clk);
        if (verbose)
            $display("txn wr=%0d rd=%0d d=%02h w_en=%0d w_addr=%0d r_en=%0d r_addr=%0d count=%0d",
                     w, r, d, bus.ram_w_en, bus.ram_w_addr, bus.ram_r_en, bus.ram_r_addr, bus.count);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    initial begin
        int exp_wa [4];
        int phase;
        exp_wa = '{3, 0, 1, 2};
        rst_n = 1'b0;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty",  bus.empty,        1);
        chk("rst_aempty", bus.almost_empty, 1);
        chk("rst_full",   bus.full,         0);
        chk("rst_afull",  bus.almost_full,  0);
        chk("rst_count",  bus.count,        0);
        chk("rst_w_en",   bus.ram_w_en,     0);
        chk("rst_r_en",   bus.ram_r_en,     0);
        chk("rst_rdv",    bus.rd_valid,     0);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fill to full, then one rejected push.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8'hA0 + 8'(i));
            chk("fill_w_en", bus.ram_w_en, 1);
            chk("fill_w_addr", bus.ram_w_addr, i);
            tick();
            chk("fill_count", bus.count, i + 1);
            chk("fill_afull", bus.almost_full, (i >= 1) ? 1 : 0);
            chk("fill_full", bus.full, (i == 3) ? 1 : 0);
        end
        step(1, 0, 8'hEE);
        chk("ovf_w_en", bus.ram_w_en, 0);
        tick();
        chk("ovf_pulse", bus.overflow, 1);
        chk("ovf_count", bus.count, 4);
        step(0, 0, 8'h00);
        tick();
        chk("ovf_clear", bus.overflow, 0);

        // Drain in order, then one rejected pop.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h00);
            chk("drain_r_addr", bus.ram_r_addr, i);
            tick();
            chk("drain_rdv", bus.rd_valid, 1);
            chk("drain_data", ram_q, 8'hA0 + i);
            chk("drain_count", bus.count, 3 - i);
        end
        step(0, 1, 8'h00);
        chk("unf_r_en", bus.ram_r_en, 0);
        tick();
        chk("unf_pulse", bus.underflow, 1);
        chk("unf_empty", bus.empty, 1);
        chk("unf_rdv", bus.rd_valid, 0);

        // Reset mid-cycle while a popped word is being presented.
        step(1, 0, 8'h55);
        tick();
        step(0, 1, 8'h00);
        tick();
        chk("mid_rdv_before", bus.rd_valid, 1);
        bus.rd_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rdv", bus.rd_valid, 0);
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_empty", bus.empty, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Wrap: push 3, pop 3, then push 4 lands on addresses 3,0,1,2.
        for (int i = 0; i < 3; i++) begin step(1, 0, 8'h10 + 8'(i)); tick(); end
        for (int i = 0; i < 3; i++) begin step(0, 1, 8'h00); tick(); end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8'hB0 + 8'(i));
            chk("wrap_w_addr", bus.ram_w_addr, exp_wa[i]);
            tick();
        end
        chk("wrap_full", bus.full, 1);
        chk("wrap_count", bus.count, 4);

        // Simultaneous push and pop at full: only the pop goes through.
        step(1, 1, 8'hFF);
        chk("simf_r_en", bus.ram_r_en, 1);
        chk("simf_w_en", bus.ram_w_en, 0);
        chk("simf_r_addr", bus.ram_r_addr, 3);
        tick();
        chk("simf_count", bus.count, 3);
        chk("simf_ovf", bus.overflow, 1);
        chk("simf_data", ram_q, 8'hB0);
        for (int i = 1; i < 4; i++) begin
            step(0, 1, 8'h00);
            tick();
            chk("wrap_data", ram_q, 8'hB0 + i);
        end

        // Simultaneous push and pop at empty: only the push goes through.
        step(1, 1, 8'hC0);
        chk("sime_w_en", bus.ram_w_en, 1);
        chk("sime_r_en", bus.ram_r_en, 0);
        tick();
        chk("sime_count", bus.count, 1);
        chk("sime_unf", bus.underflow, 1);
        chk("sime_rdv", bus.rd_valid, 0);
        step(0, 1, 8'h00);
        tick();
        chk("sime_rdv_next", bus.rd_valid, 1);
        chk("sime_data", ram_q, 8'hC0);

        // Random traffic with phases biased toward filling, draining, or balanced.
        verbose = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            phase = (c / 500) % 3;
            case (phase)
                1:       step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom));
                2:       step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
                default: step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
            endcase
            tick();
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
Single-clock FIFO controller that sequences a pseudo dual-port RAM. The RAM has 1-cycle registered read latency, and both its ports are tied to clk. The block owns the write and read pointers, occupancy count, status flags and error pulses. It drives the RAM write/read enables and addresses directly. Write data bypasses this block and goes straight to the RAM; read data comes straight from the RAM, qualified by rd_valid.

Parameters:
ADDR_WIDTH, 4, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH
AFULL_THRESH, DEPTH-2, almost_full asserted when count >= AFULL_THRESH
AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH

Ports:
clk  input  1  single clock; also drives both RAM clocks
rst_n  input  1  asynchronous active-low reset
wr_req  input  1  push request
rd_req  input  1  pop request
ram_w_en  output  1  RAM write enable
ram_w_addr  output  ADDR_WIDTH  RAM write address
ram_r_en  output  1  RAM read enable
ram_r_addr  output  ADDR_WIDTH  RAM read address
rd_valid  output  1  RAM data_out holds popped word this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  1-cycle pulse: wr_req while full
underflow  output  1  1-cycle pulse: rd_req while empty

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, overflow=0, underflow=0. Outputs during reset: empty=1, almost_empty=1, full=0, almost_full=0 (AFULL_THRESH>0), ram_w_en=0, ram_r_en=0.
- Pointers wr_ptr and rd_ptr are ADDR_WIDTH+1 bits. The RAM address is the low ADDR_WIDTH bits. The MSB toggles on wrap.
- wr_acc = wr_req & ~full. rd_acc = rd_req & ~empty. Both use the registered state of the current cycle.
- ram_w_en = wr_acc and ram_r_en = rd_acc, both combinational. ram_w_addr = wr_ptr[ADDR_WIDTH-1:0]. ram_r_addr = rd_ptr[ADDR_WIDTH-1:0].
- On posedge clk:
  - wr_ptr += wr_acc; rd_ptr += rd_acc.
  - count += wr_acc - rd_acc.
  - rd_valid <= rd_acc, so the popped word is valid exactly 1 cycle after the accepted pop.
  - overflow <= wr_req & full; underflow <= rd_req & empty.
- Flags are combinational decodes of registered count, so they are glitch-free relative to clk. Invariant: count == wr_ptr - rd_ptr (mod 2**(ADDR_WIDTH+1)). full equals the pointer MSBs differing with equal low bits.
- Simultaneous push+pop:
  - Not full, not empty: both accepted, count unchanged, different addresses.
  - Full: only pop accepted, write rejected with overflow pulse, count -> DEPTH-1.
  - Empty: only push accepted, read rejected with underflow pulse, count -> 1. No write-to-read bypass; the word is readable the following cycle.
- Wrap-around: a pointer at 2**(ADDR_WIDTH+1)-1 increments to 0. The address wraps from DEPTH-1 to 0.
- Rejected requests change no state other than the error pulse.
- Reset mid-operation immediately clears all state, including an in-flight rd_valid. RAM contents are not cleared and are treated as garbage.
- No state machine beyond pointers/count. Throughput is 1 push and 1 pop per cycle.

Decomposition:
- Shared package fifo_pkg: DEPTH derivation function, pointer/count width localparams, default threshold constants.
- Sub-module fifo_ptr: one instance each for write and read. It holds an (ADDR_WIDTH+1)-bit pointer with increment enable and exposes the address slice.
- The RAM is instantiated by the parent wrapper, not inside this block.

Test Plan:
- Reset, ADDR_WIDTH=2 (DEPTH 4): assert rst_n=0 mid-cycle -> empty=1, count=0, rd_valid=0 immediately; no ram_w_en/ram_r_en.
- Fill: 4 consecutive wr_req -> ram_w_addr 0,1,2,3; count 1..4; almost_full at count 2; full=1 after the 4th. A 5th wr_req gives ram_w_en=0, overflow pulse 1 cycle, count stays 4.
- Drain: 4 rd_req from full -> ram_r_addr 0..3, rd_valid 1 cycle after each, data 0xA0..0xA3 in order. A 5th rd_req gives underflow pulse, empty=1.
- Wrap: push 3, pop 3, push 4, pop 4 -> write addresses 3,0,1,2; read order matches; full asserts at count 4 with pointer MSBs differing.
- Simultaneous at full: wr_req=rd_req=1 -> only ram_r_en, count 4->3, overflow=1. At empty: only ram_w_en, count 0->1, underflow=1, rd_valid=0.
- Random push/pop 10k cycles against a scoreboard queue -> data order, count and flags match every cycle; never ram_w_en while full or ram_r_en while empty.
